mux_scan_nto1: RTL and testbench
================================

# mux_scan_nto1

Parametrised N-channel, W-bit registered multiplexer with two modes: manual select and automatic round-robin scan over a masked set of channels. Each channel is held for a programmable dwell time. It generalises the fixed 8:1 single-bit mux into a time-division channel scanner that feeds downstream serial or monitor logic. The output is tagged with the source channel index and a valid flag.

## Interface
- N_CH, default 8: number of input channels; must be ≥2.
- W, default 1: bits per channel.
- CNT_W, default 8: dwell counter width.
- SEL_W, default $clog2(N_CH): channel index width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  N_CH*W  channel k occupies din[k*W +: W].
- en  input  1  block enable; 0 freezes outputs and drops y_valid.
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  manual channel select.
- ch_mask  input  N_CH  scan-mode channel enable; bit k = channel k.
- dwell  input  CNT_W  extra cycles per channel in scan mode; 0 = advance every cycle.
- y  output  W  registered selected data.
- y_ch  output  SEL_W  channel index that produced y.
- y_valid  output  1  y/y_ch are meaningful this cycle.
- frame_done  output  1  one-cycle pulse on scan wrap-around.

## Operation
- The only reset is async active-low rst_n. While asserted: y=0, y_ch=0, y_valid=0, frame_done=0, cur=0, cnt=0, state=IDLE.
- Internal registers:
  - cur (SEL_W): current channel.
  - cnt (CNT_W): dwell counter.
  - state: IDLE / MANUAL / SCAN.
- State transitions, evaluated every clk edge:
  - en=0 → IDLE.
  - en=1, mode=0 → MANUAL.
  - en=1, mode=1, ch_mask≠0 → SCAN.
  - en=1, mode=1, ch_mask=0 → IDLE.
- IDLE:
  - y_valid=0, frame_done=0.
  - y and y_ch hold their last values.
  - cnt=0.
- MANUAL:
  - y ← din[sel*W +: W], y_ch ← sel, y_valid ← 1.
  - sel ≥ N_CH: y ← 0, y_valid ← 0.
  - cnt is held at 0. ch_mask and dwell are ignored.
- SCAN entry from any other state:
  - cur ← lowest set bit of ch_mask.
  - cnt ← 0; first output is on that channel.
- SCAN, each edge:
  - y ← din[cur*W +: W], y_ch ← cur, y_valid ← 1.
  - If cnt == dwell: cnt ← 0 and cur ← next set bit of ch_mask strictly above cur. If none exists, wrap to the lowest set bit.
  - Otherwise: cnt ← cnt+1.
- frame_done:
  - Asserted for exactly one cycle, coincident with the first output of the wrapped-to channel.
  - With a single enabled channel, it pulses every dwell+1 cycles.
- Mask change mid-dwell:
  - If cur's mask bit is cleared, the next edge outputs one final sample of cur, then advances immediately. cnt resets, regardless of dwell.
  - Newly set bits are picked up at the next advance.
- dwell change takes effect at the next comparison; no resynchronisation.
- cnt never exceeds dwell. If dwell is lowered below cnt, cnt == dwell is false until cnt wraps, so advance on cnt ≥ dwell.

## Timing
- Latency is 1 clock in all modes: y at edge n+1 reflects din and the select at edge n.
- No combinational path from any input to any output.
- Scan mode: each enabled channel appears for exactly dwell+1 consecutive valid cycles.
- Full frame length = popcount(ch_mask) × (dwell+1) cycles.
- Mode switch MANUAL→SCAN: the first scan sample appears on the edge after mode=1 is sampled.
- Mode switch SCAN→MANUAL: the first sample at sel appears on the edge after mode=0 is sampled. No residual scan sample is emitted.
- en deassert: y_valid=0 from the next edge.
- en reassert in scan mode restarts from the lowest enabled channel.
- Reset assertion mid-scan clears all outputs asynchronously, without waiting for clk.
- After reset release, the first valid output comes 1 edge after en=1.

## Test plan
- Manual sweep: N_CH=8, W=1, din=8'b10101011, mode=0, en=1, sel=0..7, one per cycle → y = 1,1,0,1,0,1,0,1 one cycle after each sel; y_ch tracks sel; y_valid=1 throughout.
- Scan, dwell=0: ch_mask=8'hFF, din=8'hA5 → y_ch cycles 0..7 each cycle; y matches din bits. frame_done pulses at every return to ch 0 (period 8).
- Scan with mask and dwell: N_CH=8, W=4, ch_mask=8'b0010_0100, dwell=2 → y_ch = 2,2,2,5,5,5,2,… ; frame_done high on each first ch-2 cycle after the first frame.
- Mask edit mid-dwell: dwell=5, scanning ch 2, clear bit 2 at cnt=1 → one more ch-2 sample, then ch 5 with cnt=0.
- Edge configurations: sel=9 with N_CH=10 valid vs. sel=12 → y_valid=0. ch_mask=0 in scan → y_valid=0, outputs held. Single enabled channel with dwell=3 → frame_done every 4 cycles.
- Reset mid-scan: assert rst_n=0 between edges → y, y_ch, y_valid, frame_done = 0 immediately. After release with en=1, scan restarts at the lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_nto1.sv
// N-channel registered multiplexer with two modes: manual select, or round-robin
// scan over masked channels with a per-channel dwell. Output carries its source index.
module mux_scan_nto1 #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int CNT_W = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   din,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [CNT_W-1:0]    dwell,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    y_ch,
  output logic                y_valid,
  output logic                frame_done
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam int N_SLOT = 2 ** SEL_W;

  state_t            state;
  logic [SEL_W-1:0]  cur;
  logic [CNT_W-1:0]  cnt;
  logic              wrap_pend;

  // Unused index codes above N_CH read as zero, so an out-of-range sel yields y=0.
  logic [W-1:0] ch_data [N_SLOT];

  for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
    if (k < N_CH) begin : g_ch
      assign ch_data[k] = din[k*W +: W];
    end else begin : g_pad
      assign ch_data[k] = '0;
    end
  end

  function automatic logic [SEL_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // MSB of the result flags that no enabled channel lies above c (wrap-around).
  function automatic logic [SEL_W:0] next_ch(input logic [N_CH-1:0] m,
                                             input logic [SEL_W-1:0] c);
    logic [SEL_W:0] r;
    r = {1'b1, lowest_ch(m)};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = {1'b0, SEL_W'(i)};
    end
    return r;
  endfunction

  logic              go_idle;
  logic              scan_entry;
  logic [SEL_W-1:0]  eff_cur;
  logic [CNT_W-1:0]  eff_cnt;
  logic              advance;
  logic [SEL_W-1:0]  nxt_cur;
  logic              nxt_wrap;
  logic              sel_ok;

  always_comb begin
    go_idle    = !en || (mode && (ch_mask == '0));
    scan_entry = (state != SCAN);
    eff_cur    = scan_entry ? lowest_ch(ch_mask) : cur;
    eff_cnt    = scan_entry ? '0 : cnt;
    // A channel whose mask bit was just cleared gets one last sample, then we move on.
    advance    = (eff_cnt >= dwell) || !ch_mask[eff_cur];
    {nxt_wrap, nxt_cur} = next_ch(ch_mask, eff_cur);
    sel_ok     = int'(sel) < N_CH;
  end

  // Stage p0 -> output register: single-cycle latency from every input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      wrap_pend  <= 1'b0;
      y          <= '0;
      y_ch       <= '0;
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else if (go_idle) begin
      state      <= IDLE;
      cnt        <= '0;
      wrap_pend  <= 1'b0;
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else if (!mode) begin
      state      <= MANUAL;
      cnt        <= '0;
      wrap_pend  <= 1'b0;
      y          <= sel_ok ? ch_data[sel] : '0;
      y_ch       <= sel;
      y_valid    <= sel_ok;
      frame_done <= 1'b0;
    end else begin
      state      <= SCAN;
      y          <= ch_data[eff_cur];
      y_ch       <= eff_cur;
      y_valid    <= 1'b1;
      frame_done <= wrap_pend && !scan_entry;
      if (advance) begin
        cnt       <= '0;
        cur       <= nxt_cur;
        wrap_pend <= nxt_wrap;
      end else begin
        cnt       <= eff_cnt + CNT_W'(1);
        cur       <= eff_cur;
        wrap_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench for mux_scan_nto1: a behavioural model pushes the expected
// output for every driven cycle; it is popped and compared one edge later.
`timescale 1ns/1ps
module tb_mux_scan_nto1;
  localparam int N_CH = 8, W = 4, CNT_W = 8, SEL_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_CH*W-1:0] din;
  logic              en, mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH-1:0]   ch_mask;
  logic [CNT_W-1:0]  dwell;
  logic [W-1:0]      y;
  logic [SEL_W-1:0]  y_ch;
  logic              y_valid, frame_done;

  mux_scan_nto1 #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W), .SEL_W(SEL_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .dwell(dwell), .y(y), .y_ch(y_ch), .y_valid(y_valid),
    .frame_done(frame_done)
  );

  // Ten-channel instance for the non-power-of-two select range.
  logic [39:0] din1;
  logic [3:0]  sel1;
  logic [9:0]  mask1;
  logic [7:0]  dwell1;
  logic [3:0]  y1;
  logic [3:0]  y1_ch;
  logic        y1_valid, fd1;

  mux_scan_nto1 #(.N_CH(10), .W(4), .CNT_W(8)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .din(din1), .en(1'b1), .mode(1'b0), .sel(sel1),
    .ch_mask(mask1), .dwell(dwell1), .y(y1), .y_ch(y1_ch), .y_valid(y1_valid),
    .frame_done(fd1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]     y;
    logic [SEL_W-1:0] ych;
    logic             vld;
    logic             fd;
  } exp_t;

  exp_t sb[$];

  int   m_state;  // 0 idle, 1 manual, 2 scan
  int   m_cur, m_cnt;
  bit   m_wrap;
  exp_t m_out;

  function automatic logic [W-1:0] chan(input int c);
    return din[c*W +: W];
  endfunction

  function automatic int lowest_set();
    for (int c = 0; c < N_CH; c++) if (ch_mask[c]) return c;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_cnt = 0; m_wrap = 0;
    m_out.y = '0; m_out.ych = '0; m_out.vld = 0; m_out.fd = 0;
  endtask

  task automatic model_step();
    int nxt;
    if (!en || (mode && ch_mask == '0)) begin
      m_state = 0; m_cnt = 0; m_wrap = 0;
      m_out.vld = 0; m_out.fd = 0;
    end else if (!mode) begin
      m_state = 1; m_cnt = 0; m_wrap = 0;
      m_out.y = chan(int'(sel)); m_out.ych = sel; m_out.vld = 1; m_out.fd = 0;
    end else begin
      if (m_state != 2) begin
        m_cur = lowest_set(); m_cnt = 0; m_wrap = 0;
      end
      m_out.y = chan(m_cur); m_out.ych = SEL_W'(m_cur); m_out.vld = 1; m_out.fd = m_wrap;
      m_wrap = 0;
      if (m_cnt >= int'(dwell) || !ch_mask[3'(m_cur)]) begin
        m_cnt = 0;
        nxt = -1;
        for (int c = m_cur + 1; c < N_CH; c++) if (ch_mask[c] && nxt < 0) nxt = c;
        if (nxt < 0) begin
          m_wrap = 1;
          nxt = lowest_set();
        end
        m_cur = nxt;
      end else begin
        m_cnt++;
      end
      m_state = 2;
    end
    sb.push_back(m_out);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".y"},     32'(y),          32'(e.y));
    chk({tag, ".ych"},   32'(y_ch),       32'(e.ych));
    chk({tag, ".vld"},   32'(y_valid),    32'(e.vld));
    chk({tag, ".fd"},    32'(frame_done), 32'(e.fd));
  endtask

  task automatic rand_din();
    for (int k = 0; k < N_CH; k++) din[k*W +: W] = W'($urandom_range(0, 15));
  endtask

  initial begin
    logic [7:0] pat;
    int fd_cnt;

    rst_n = 0; en = 0; mode = 0; sel = '0; ch_mask = '0; dwell = '0; din = '0;
    for (int k = 0; k < 10; k++) din1[k*4 +: 4] = 4'(k + 1);
    sel1 = 4'd9; mask1 = '0; dwell1 = '0;
    model_reset();

    #12;
    chk("rst.y", 32'(y), 0);
    chk("rst.ych", 32'(y_ch), 0);
    chk("rst.vld", 32'(y_valid), 0);
    chk("rst.fd", 32'(frame_done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    cycle("idle");

    // Manual sweep: bit 0 of each channel carries the 8'b10101011 pattern.
    pat = 8'b1010_1011;
    for (int k = 0; k < N_CH; k++) din[k*W +: W] = W'({k[2:0], pat[k]});
    en = 1; mode = 0;
    for (int s = 0; s < N_CH; s++) begin
      sel = SEL_W'(s);
      cycle("man");
      chk("man.bit", 32'(y[0]), 32'(pat[s]));
    end
    chk("n10.sel9.y", 32'(y1), 10);
    chk("n10.sel9.ych", 32'(y1_ch), 9);
    chk("n10.sel9.vld", 32'(y1_valid), 1);
    sel1 = 4'd12;
    cycle("man");
    chk("n10.sel12.y", 32'(y1), 0);
    chk("n10.sel12.vld", 32'(y1_valid), 0);

    // Scan every channel with dwell=0: one channel per cycle, wrap pulse every 8.
    for (int k = 0; k < N_CH; k++) din[k*W +: W] = W'(k[0] ? 4'h5 : 4'hA);
    ch_mask = 8'hFF; dwell = 0; mode = 1;
    fd_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cycle("scan0");
      chk("scan0.ch", 32'(y_ch), 32'(i % 8));
      fd_cnt += int'(frame_done);
    end
    chk("scan0.fdcount", 32'(fd_cnt), 2);

    // SCAN -> MANUAL -> SCAN: no residual sample, scan restarts at lowest channel.
    mode = 0; sel = 3'd6;
    cycle("sw.man");
    chk("sw.man.ch", 32'(y_ch), 6);
    mode = 1; ch_mask = 8'b0011_0000;
    cycle("sw.scan");
    chk("sw.scan.ch", 32'(y_ch), 4);

    // Masked scan with dwell=2 over channels 2 and 5.
    en = 0; cycle("gap");
    en = 1; ch_mask = 8'b0010_0100; dwell = 2;
    for (int i = 0; i < 12; i++) begin
      rand_din();
      cycle("scan2");
      chk("scan2.ch", 32'(y_ch), ((i / 3) % 2) ? 5 : 2);
      chk("scan2.fd", 32'(frame_done), 32'(i == 6));
    end

    // Clear the current channel's mask bit mid-dwell.
    en = 0; cycle("gap");
    en = 1; dwell = 5;
    cycle("medit");
    ch_mask = 8'b0010_0000;
    cycle("medit");
    chk("medit.last", 32'(y_ch), 2);
    cycle("medit");
    chk("medit.next", 32'(y_ch), 5);
    for (int i = 0; i < 3; i++) cycle("medit");
    dwell = 1;   // lowered below cnt: advance on the next compare
    for (int i = 0; i < 4; i++) cycle("dwlow");

    // Empty mask in scan mode: outputs held, no valid.
    ch_mask = '0;
    cycle("mask0");
    chk("mask0.vld", 32'(y_valid), 0);

    // Single enabled channel with dwell=3.
    ch_mask = 8'b0000_1000; dwell = 3;
    fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("single");
      fd_cnt += int'(frame_done);
    end
    chk("single.fdcount", 32'(fd_cnt), 3);

    // Reset asserted between edges mid-scan.
    ch_mask = 8'b1010_0100; dwell = 1;
    for (int i = 0; i < 3; i++) cycle("prerst");
    #2 rst_n = 0;
    #1;
    chk("arst.y", 32'(y), 0);
    chk("arst.ych", 32'(y_ch), 0);
    chk("arst.vld", 32'(y_valid), 0);
    chk("arst.fd", 32'(frame_done), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    cycle("postrst");
    chk("postrst.ch", 32'(y_ch), 2);
    for (int i = 0; i < 6; i++) cycle("postrst");

    // Random mixed traffic against the model.
    for (int i = 0; i < 60; i++) begin
      rand_din();
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 5) == 0) ch_mask = N_CH'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dwell = CNT_W'($urandom_range(0, 3));
      sel = SEL_W'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
